dmi_initiator: RTL and testbench



---
 rtl/dm_pkg.sv | 33 +++
 rtl/dmi_initiator.sv | 183 ++++++++++++++++++
 tb/tb_dmi_initiator.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Debug-module package: DMI transport types shared by the DTM-side initiator
// and the debug module, plus the initiator's status codes and state encoding.
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    localparam logic [1:0] DmiSuccess = 2'd0;
    localparam logic [1:0] DmiFailed  = 2'd2;
    localparam logic [1:0] DmiBusy    = 2'd3;

    typedef enum logic [1:0] {
        DmiIdle = 2'd0,
        DmiReq  = 2'd1,
        DmiResp = 2'd2,
        DmiRst  = 2'd3
    } dmi_init_state_e;

endpackage

// File: rtl/dmi_initiator.sv
// Requester end of the DMI link: one outstanding request at a time, sticky
// error status, and a watchdog that recovers a hung DM by pulsing its reset.
module dmi_initiator
    import dm::*;
#(
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned CntWidth      = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_op_i,
    input  logic [6:0]  cmd_addr_i,
    input  logic [31:0] cmd_data_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic [1:0]  rsp_status_o,
    input  logic        dmireset_i,
    input  logic        dmihardreset_i,
    output logic        busy_o,
    output logic [1:0]  dmistat_o,
    output logic        dmi_rst_no,
    output logic        dmi_req_valid_o,
    input  logic        dmi_req_ready_i,
    output dmi_req_t    dmi_req_o,
    input  logic        dmi_resp_valid_i,
    output logic        dmi_resp_ready_o,
    input  dmi_resp_t   dmi_resp_i
);

    localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TimeoutCycles - 32'd1);
    localparam logic [CntWidth-1:0] CntOne      = CntWidth'(32'd1);

    dmi_init_state_e    state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    dmi_req_t           req_q, req_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic [1:0]         rsp_status_q, rsp_status_d;
    logic [1:0]         dmistat_q, dmistat_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               req_valid_q, req_valid_d;
    logic               resp_ready_q, resp_ready_d;
    logic               dmi_rst_n_q, dmi_rst_n_d;
    logic               busy_q, busy_d;
    logic               err_set_s;
    logic [1:0]         err_val_s;
    logic               timeout_hit_s;

    assign timeout_hit_s = (TimeoutCycles != 32'd0) && (cnt_q == TimeoutLast);

    // Next-state, response capture and sticky status.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        rsp_valid_d  = 1'b0;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        err_set_s    = 1'b0;
        err_val_s    = DmiSuccess;

        if (dmihardreset_i) begin
            state_d = DmiRst;
        end else begin
            case (state_q)
                DmiIdle: begin
                    if (!cmd_valid_i) begin
                        state_d = DmiIdle;
                    end else if (dmistat_q != DmiSuccess) begin
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = dmistat_q;
                    end else if (cmd_op_i == DTM_NOP) begin
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = DmiSuccess;
                    end else begin
                        req_d   = '{addr: cmd_addr_i, op: dtm_op_e'(cmd_op_i), data: cmd_data_i};
                        cnt_d   = '0;
                        state_d = DmiReq;
                    end
                end
                DmiReq: begin
                    cnt_d = cnt_q + CntOne;
                    if (dmi_req_ready_i) begin
                        state_d = DmiResp;
                    end else if (timeout_hit_s) begin
                        state_d      = DmiRst;
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = DmiBusy;
                        err_set_s    = 1'b1;
                        err_val_s    = DmiBusy;
                    end else begin
                        state_d = DmiReq;
                    end
                end
                DmiResp: begin
                    cnt_d = cnt_q + CntOne;
                    if (dmi_resp_valid_i) begin
                        state_d      = DmiIdle;
                        rsp_valid_d  = 1'b1;
                        rsp_data_d   = dmi_resp_i.data;
                        rsp_status_d = dmi_resp_i.resp;
                        err_set_s    = (dmi_resp_i.resp != DmiSuccess);
                        err_val_s    = dmi_resp_i.resp;
                    end else if (timeout_hit_s) begin
                        state_d      = DmiRst;
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = DmiBusy;
                        err_set_s    = 1'b1;
                        err_val_s    = DmiBusy;
                    end else begin
                        state_d = DmiResp;
                    end
                end
                DmiRst: begin
                    state_d = DmiIdle;
                end
                default: begin
                    state_d = DmiIdle;
                end
            endcase
        end

        // Clearing wins over a simultaneous error; the first error sticks.
        if (dmihardreset_i || dmireset_i) begin
            dmistat_d = DmiSuccess;
        end else if (err_set_s && (dmistat_q == DmiSuccess)) begin
            dmistat_d = err_val_s;
        end else begin
            dmistat_d = dmistat_q;
        end

        cmd_ready_d  = (state_d == DmiIdle);
        req_valid_d  = (state_d == DmiReq);
        resp_ready_d = (state_d == DmiResp);
        dmi_rst_n_d  = (state_d != DmiRst);
        busy_d       = (state_d != DmiIdle);
    end

    // State and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= DmiIdle;
            cnt_q        <= '0;
            req_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 32'h0000_0000;
            rsp_status_q <= DmiSuccess;
            dmistat_q    <= DmiSuccess;
            cmd_ready_q  <= 1'b1;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b0;
            dmi_rst_n_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            dmistat_q    <= dmistat_d;
            cmd_ready_q  <= cmd_ready_d;
            req_valid_q  <= req_valid_d;
            resp_ready_q <= resp_ready_d;
            dmi_rst_n_q  <= dmi_rst_n_d;
            busy_q       <= busy_d;
        end
    end

    assign cmd_ready_o      = cmd_ready_q;
    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_data_o       = rsp_data_q;
    assign rsp_status_o     = rsp_status_q;
    assign busy_o           = busy_q;
    assign dmistat_o        = dmistat_q;
    assign dmi_rst_no       = dmi_rst_n_q;
    assign dmi_req_valid_o  = req_valid_q;
    assign dmi_req_o        = req_q;
    assign dmi_resp_ready_o = resp_ready_q;

endmodule

// File: tb/tb_dmi_initiator.sv
// Scoreboard bench for dmi_initiator: a command-level model predicts each
// result strobe and the sticky status; a monitor pops and compares strobes.
module tb_dmi_initiator;
    import dm::*;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i;
    logic [6:0]  cmd_addr_i;
    logic [31:0] cmd_data_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic [1:0]  rsp_status_o;
    logic        dmireset_i;
    logic        dmihardreset_i;
    logic        busy_o;
    logic [1:0]  dmistat_o;
    logic        dmi_rst_no;
    logic        dmi_req_valid_o;
    logic        dmi_req_ready_i;
    dmi_req_t    dmi_req_o;
    logic        dmi_resp_valid_i;
    logic        dmi_resp_ready_o;
    dmi_resp_t   dmi_resp_i;

    always #5 clk = ~clk;

    dmi_initiator #(.TimeoutCycles(TO), .CntWidth(16)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i), .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_status_o(rsp_status_o),
        .dmireset_i(dmireset_i), .dmihardreset_i(dmihardreset_i),
        .busy_o(busy_o), .dmistat_o(dmistat_o), .dmi_rst_no(dmi_rst_no),
        .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
        .dmi_req_o(dmi_req_o),
        .dmi_resp_valid_i(dmi_resp_valid_i), .dmi_resp_ready_o(dmi_resp_ready_o),
        .dmi_resp_i(dmi_resp_i)
    );

    typedef struct packed {
        logic [1:0]  st;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_acc = 0;
    int          last_rsp_cyc = 0;
    int          rst_pulses = 0;
    int          low_cnt = 0;
    logic [1:0]  m_stat;
    logic [31:0] m_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every result strobe must match the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (rst_ni && rsp_valid_o) begin
            last_rsp_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp status=%0d data=%0h (t=%0t)", rsp_status_o, rsp_data_o, $time);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_status", {62'd0, rsp_status_o}, {62'd0, e.st});
                chk("rsp_data", {32'd0, rsp_data_o}, {32'd0, e.data});
            end
        end
    end

    // DMI reset pulses must last exactly one cycle.
    always @(negedge clk) begin
        if (rst_ni && !dmi_rst_no) begin
            low_cnt++;
        end else if (low_cnt > 0) begin
            chk("dmi_rst_pulse_len", 64'(low_cnt), 64'd1);
            rst_pulses++;
            low_cnt = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((busy_o || !cmd_ready_o) && g < 100) begin
            tick();
            g++;
        end
        if (busy_o || !cmd_ready_o) chk("idle_wait_expired", 64'd1, 64'd0);
    endtask

    task automatic check_reset_values();
        chk("rst_cmd_ready", {63'd0, cmd_ready_o}, 64'd1);
        chk("rst_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
        chk("rst_rsp_data", {32'd0, rsp_data_o}, 64'd0);
        chk("rst_rsp_status", {62'd0, rsp_status_o}, 64'd0);
        chk("rst_dmistat", {62'd0, dmistat_o}, 64'd0);
        chk("rst_dmi_rst_n", {63'd0, dmi_rst_no}, 64'd1);
        chk("rst_req_valid", {63'd0, dmi_req_valid_o}, 64'd0);
        chk("rst_req", {23'd0, dmi_req_o}, 64'd0);
        chk("rst_resp_ready", {63'd0, dmi_resp_ready_o}, 64'd0);
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
    endtask

    task automatic pulse_dmireset();
        dmireset_i = 1'b1;
        tick();
        dmireset_i = 1'b0;
        m_stat = 2'd0;
        chk("dmistat_after_dmireset", {62'd0, dmistat_o}, 64'd0);
    endtask

    // Issue one command and play the DM side with the given delays.
    task automatic do_cmd(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                          input int rd, input int sd, input logic [1:0] rc, input logic [31:0] rdat);
        exp_t       e;
        logic [40:0] exp_req;
        bit         exp_dmi;
        bit         done;
        int         k;
        int         phase;
        int         g;
        wait_idle();
        exp_dmi = 1'b0;
        if (m_stat != 2'd0) begin
            e = '{st: m_stat, data: m_data};
        end else if (op == 2'd0) begin
            e = '{st: 2'd0, data: m_data};
        end else begin
            exp_dmi = 1'b1;
            if ((rd >= int'(TO)) || (rd + 1 + sd > int'(TO) - 1)) begin
                e = '{st: 2'd3, data: m_data};
                m_stat = 2'd3;
            end else begin
                e = '{st: rc, data: rdat};
                m_data = rdat;
                if (rc != 2'd0) m_stat = rc;
            end
        end
        exp_q.push_back(e);
        exp_req = {addr, op, data};
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_addr_i  = addr;
        cmd_data_i  = data;
        last_acc    = cyc;
        tick();
        cmd_valid_i = 1'b0;
        chk("dmi_req_valid_after_accept", {63'd0, dmi_req_valid_o}, {63'd0, exp_dmi});
        done = !exp_dmi;
        k = 0;
        phase = 0;
        g = 0;
        while (!done && g < 64) begin
            dmi_req_ready_i  = 1'b0;
            dmi_resp_valid_i = 1'b0;
            if (phase == 0) begin
                if (!dmi_req_valid_o) begin
                    done = 1'b1;
                end else begin
                    chk("dmi_req_stable", {23'd0, dmi_req_o}, {23'd0, exp_req});
                    if (k == rd) dmi_req_ready_i = 1'b1;
                end
            end else begin
                if (!dmi_resp_ready_o) begin
                    done = 1'b1;
                end else if (k == sd) begin
                    dmi_resp_valid_i = 1'b1;
                    dmi_resp_i = '{data: rdat, resp: rc};
                end
            end
            if (!done) begin
                tick();
                if (phase == 0 && dmi_req_ready_i) begin
                    phase = 1;
                    k = 0;
                end else if (phase == 1 && dmi_resp_valid_i) begin
                    done = 1'b1;
                end else begin
                    k++;
                end
            end
            g++;
        end
        dmi_req_ready_i  = 1'b0;
        dmi_resp_valid_i = 1'b0;
        wait_idle();
        tick();
        chk("dmistat", {62'd0, dmistat_o}, {62'd0, m_stat});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int pulses0;
        int r;
        int rd;
        rst_ni = 1'b0;
        cmd_valid_i = 1'b0; cmd_op_i = 2'd0; cmd_addr_i = 7'd0; cmd_data_i = 32'd0;
        dmireset_i = 1'b0; dmihardreset_i = 1'b0;
        dmi_req_ready_i = 1'b0; dmi_resp_valid_i = 1'b0; dmi_resp_i = '0;
        m_stat = 2'd0; m_data = 32'd0;
        repeat (3) tick();
        check_reset_values();
        rst_ni = 1'b1;
        tick();

        do_cmd(2'd2, 7'h10, 32'h8000_0001, 0, 0, 2'd0, 32'h0000_0000);
        chk("write_latency", 64'(last_rsp_cyc - last_acc), 64'd3);
        do_cmd(2'd1, 7'h11, 32'h0, 5, 1, 2'd0, 32'h0003_0C82);
        do_cmd(2'd1, 7'h12, 32'h0, 0, 0, 2'd2, 32'h1234_5678);
        do_cmd(2'd2, 7'h13, 32'hDEAD_BEEF, 0, 0, 2'd0, 32'h0);
        chk("drop_latency", 64'(last_rsp_cyc - last_acc), 64'd1);
        pulse_dmireset();
        do_cmd(2'd1, 7'h11, 32'h0, 1, 0, 2'd0, 32'hCAFE_0011);

        pulses0 = rst_pulses;
        do_cmd(2'd1, 7'h20, 32'h0, 0, 99, 2'd0, 32'h0);
        chk("timeout_latency", 64'(last_rsp_cyc - last_acc), 64'(TO + 1));
        chk("timeout_rst_pulses", 64'(rst_pulses - pulses0), 64'd1);
        pulse_dmireset();

        do_cmd(2'd0, 7'h05, 32'h0, 0, 0, 2'd0, 32'h0);
        chk("nop_latency", 64'(last_rsp_cyc - last_acc), 64'd1);

        // Hard reset in RESP while the response arrives: no strobe, status cleared.
        pulses0 = rst_pulses;
        wait_idle();
        cmd_valid_i = 1'b1; cmd_op_i = 2'd1; cmd_addr_i = 7'h30;
        tick();
        cmd_valid_i = 1'b0;
        dmi_req_ready_i = 1'b1;
        tick();
        dmi_req_ready_i = 1'b0;
        chk("hr_resp_ready", {63'd0, dmi_resp_ready_o}, 64'd1);
        dmi_resp_valid_i = 1'b1;
        dmi_resp_i = '{data: 32'h5555_AAAA, resp: 2'd2};
        dmihardreset_i = 1'b1;
        tick();
        dmi_resp_valid_i = 1'b0;
        dmihardreset_i = 1'b0;
        chk("hr_dmi_rst_n", {63'd0, dmi_rst_no}, 64'd0);
        chk("hr_busy", {63'd0, busy_o}, 64'd1);
        tick();
        chk("hr_idle", {63'd0, cmd_ready_o}, 64'd1);
        chk("hr_dmistat", {62'd0, dmistat_o}, 64'd0);
        tick();
        chk("hr_rst_pulses", 64'(rst_pulses - pulses0), 64'd1);
        chk("hr_rsp_data_held", {32'd0, rsp_data_o}, {32'd0, m_data});

        // Reset mid-transaction.
        cmd_valid_i = 1'b1; cmd_op_i = 2'd2; cmd_addr_i = 7'h44; cmd_data_i = 32'h0BAD_F00D;
        tick();
        cmd_valid_i = 1'b0;
        chk("mid_req_valid", {63'd0, dmi_req_valid_o}, 64'd1);
        rst_ni = 1'b0;
        tick();
        check_reset_values();
        rst_ni = 1'b1;
        m_stat = 2'd0;
        m_data = 32'd0;
        tick();

        for (int i = 0; i < 40; i++) begin
            if (m_stat != 2'd0 && $urandom_range(1, 0) == 1) pulse_dmireset();
            r  = $urandom_range(7, 0);
            rd = ($urandom_range(9, 0) < 8) ? $urandom_range(6, 0) : 9;
            do_cmd(2'($urandom_range(2, 0)), 7'($urandom), $urandom, rd, $urandom_range(6, 0),
                   (r == 6) ? 2'd2 : ((r == 7) ? 2'd3 : 2'd0), $urandom);
        end

        repeat (3) tick();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
